instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/mips_pkg.sv | 29 ++
 rtl/instr_pack.sv | 31 +++
 rtl/instr_encoder.sv | 115 +++++++++++
 tb/tb_instr_encoder.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants, op_kind enumeration and loader state type.
package mips_pkg;

   localparam logic [5:0] OPC_R    = 6'b000000;
   localparam logic [5:0] OPC_LW   = 6'b100011;
   localparam logic [5:0] OPC_SW   = 6'b101011;
   localparam logic [5:0] OPC_BEQ  = 6'b000100;
   localparam logic [5:0] OPC_ADDI = 6'b001000;
   localparam logic [5:0] OPC_BNE  = 6'b000101;
   localparam logic [5:0] OPC_J    = 6'b000010;

   typedef enum logic [2:0] {
      OP_R    = 3'd0,
      OP_LW   = 3'd1,
      OP_SW   = 3'd2,
      OP_BEQ  = 3'd3,
      OP_ADDI = 3'd4,
      OP_BNE  = 3'd5,
      OP_J    = 3'd6,
      OP_ILL  = 3'd7
   } op_kind_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: op_kind plus instruction fields -> 32-bit MIPS word.
module instr_pack
   import mips_pkg::*;
(
   input  logic [2:0]  op_kind_i,
   input  logic [4:0]  rs_i,
   input  logic [4:0]  rt_i,
   input  logic [4:0]  rd_i,
   input  logic [5:0]  funct_i,
   input  logic [15:0] imm_i,
   input  logic [25:0] target_i,
   output logic [31:0] word_o,
   output logic        illegal_o
);

   always_comb begin
      word_o    = '0;
      illegal_o = 1'b0;
      case (op_kind_i)
         OP_R:    word_o = {OPC_R, rs_i, rt_i, rd_i, 5'b0, funct_i};
         OP_LW:   word_o = {OPC_LW, rs_i, rt_i, imm_i};
         OP_SW:   word_o = {OPC_SW, rs_i, rt_i, imm_i};
         OP_BEQ:  word_o = {OPC_BEQ, rs_i, rt_i, imm_i};
         OP_ADDI: word_o = {OPC_ADDI, rs_i, rt_i, imm_i};
         OP_BNE:  word_o = {OPC_BNE, rs_i, rt_i, imm_i};
         OP_J:    word_o = {OPC_J, target_i};
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Instruction loader: encodes field bundles and streams them into instruction memory.
module instr_encoder
   import mips_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned DEPTH     = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  op_kind,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [5:0]  funct,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   input  logic        last,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int unsigned    CW      = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   state_e        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          err_q, err_d;
   logic [31:0]   word;
   logic          illegal;
   logic          accept;

   instr_pack u_pack (
      .op_kind_i (op_kind),
      .rs_i      (rs),
      .rt_i      (rt),
      .rd_i      (rd),
      .funct_i   (funct),
      .imm_i     (imm),
      .target_i  (target),
      .word_o    (word),
      .illegal_o (illegal)
   );

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      we_d     = 1'b0;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      err_d    = err_q;
      // start masks acceptance so a restart never consumes the pending bundle
      in_ready = (state_q == ST_LOAD) && (count_q < DEPTH_C) && !start;
      accept   = in_valid && in_ready;

      if (accept) begin
         if (illegal) begin
            err_d = 1'b1;
         end else begin
            we_d    = 1'b1;
            addr_d  = BASE_ADDR + (32'(count_q) << 2);
            wdata_d = word;
            count_d = count_q + CW'(1);
         end
      end

      case (state_q)
         ST_IDLE:  if (start) state_d = ST_LOAD;
         ST_LOAD:  if (accept && last) state_d = ST_FLUSH;
         ST_FLUSH: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      if (start) begin
         state_d = ST_LOAD;
         count_d = '0;
         err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         we_q    <= 1'b0;
         addr_q  <= BASE_ADDR;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
      end
   end

   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign err        = err_q;
   assign busy       = (state_q != ST_IDLE);
   assign done       = (state_q == ST_FLUSH);

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: two instances (default and DEPTH=2 at a non-zero base) against a session-level model.
module tb_instr_encoder;

   localparam logic [31:0] BASE1 = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_r = 1'b0;
   logic        valid_r = 1'b0;
   logic [2:0]  op_r = '0;
   logic [4:0]  rs_r = '0, rt_r = '0, rd_r = '0;
   logic [5:0]  funct_r = '0;
   logic [15:0] imm_r = '0;
   logic [25:0] tgt_r = '0;
   logic        last_r = 1'b0;

   logic [1:0]  rdy_w, we_w, busy_w, done_w, err_w;
   logic [31:0] addr_w [2];
   logic [31:0] data_w [2];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   instr_encoder dut0 (
      .clk(clk), .rst_n(rst_n), .start(start_r), .in_valid(valid_r), .in_ready(rdy_w[0]),
      .op_kind(op_r), .rs(rs_r), .rt(rt_r), .rd(rd_r), .funct(funct_r), .imm(imm_r),
      .target(tgt_r), .last(last_r), .imem_we(we_w[0]), .imem_addr(addr_w[0]),
      .imem_wdata(data_w[0]), .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0])
   );

   instr_encoder #(.BASE_ADDR(BASE1), .DEPTH(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start_r), .in_valid(valid_r), .in_ready(rdy_w[1]),
      .op_kind(op_r), .rs(rs_r), .rt(rt_r), .rd(rd_r), .funct(funct_r), .imm(imm_r),
      .target(tgt_r), .last(last_r), .imem_we(we_w[1]), .imem_addr(addr_w[1]),
      .imem_wdata(data_w[1]), .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1])
   );

   // ---------------- behavioural model ----------------
   int unsigned dep [2] = '{256, 2};
   logic [31:0] base [2] = '{32'h0, BASE1};

   // phase: 0 = no session, 1 = loading, 2 = final flush cycle
   int          m_ph [2], n_ph [2];
   int unsigned m_n [2], n_n [2];
   bit          m_err [2], n_err [2];
   bit          m_we [2], n_we [2];
   logic [31:0] m_addr [2], n_addr [2];
   logic [31:0] m_data [2], n_data [2];

   typedef struct packed { logic [31:0] a; logic [31:0] d; logic dn; } wr_t;
   wr_t log0[$];
   wr_t log1[$];

   function automatic logic [31:0] encode(int op, logic [4:0] s, logic [4:0] t, logic [4:0] d,
                                          logic [5:0] f, logic [15:0] im, logic [25:0] tg);
      logic [31:0] opc [7];
      opc = '{32'h00, 32'h23, 32'h2B, 32'h04, 32'h08, 32'h05, 32'h02};
      if (op == 0) return (32'(s) << 21) | (32'(t) << 16) | (32'(d) << 11) | 32'(f);
      if (op == 6) return (opc[6] << 26) | 32'(tg);
      return (opc[op] << 26) | (32'(s) << 21) | (32'(t) << 16) | 32'(im);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_ph[i] = 0; m_n[i] = 0; m_err[i] = 0; m_we[i] = 0;
         m_addr[i] = base[i]; m_data[i] = '0;
         n_ph[i] = 0; n_n[i] = 0; n_err[i] = 0; n_we[i] = 0;
         n_addr[i] = base[i]; n_data[i] = '0;
      end
   endtask

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         bit rdy, acc;
         rdy = (m_ph[i] == 1) && (m_n[i] < dep[i]) && !start_r;
         chk($sformatf("in_ready[%0d]", i), 32'(rdy_w[i]), 32'(rdy));
         chk($sformatf("busy[%0d]", i), 32'(busy_w[i]), 32'(m_ph[i] != 0));
         chk($sformatf("done[%0d]", i), 32'(done_w[i]), 32'(m_ph[i] == 2));
         chk($sformatf("err[%0d]", i), 32'(err_w[i]), 32'(m_err[i]));
         chk($sformatf("we[%0d]", i), 32'(we_w[i]), 32'(m_we[i]));
         chk($sformatf("addr[%0d]", i), addr_w[i], m_addr[i]);
         chk($sformatf("wdata[%0d]", i), data_w[i], m_data[i]);
         if (we_w[i]) begin
            if (i == 0) log0.push_back('{addr_w[i], data_w[i], done_w[i]});
            else        log1.push_back('{addr_w[i], data_w[i], done_w[i]});
         end

         acc      = valid_r && rdy;
         n_ph[i]  = m_ph[i];
         n_n[i]   = m_n[i];
         n_err[i] = m_err[i];
         n_we[i]  = 0;
         n_addr[i] = m_addr[i];
         n_data[i] = m_data[i];
         if (acc && op_r == 3'd7) n_err[i] = 1;
         if (acc && op_r != 3'd7) begin
            n_we[i]   = 1;
            n_addr[i] = base[i] + 4 * m_n[i];
            n_data[i] = encode(int'(op_r), rs_r, rt_r, rd_r, funct_r, imm_r, tgt_r);
            n_n[i]    = m_n[i] + 1;
         end
         if (start_r) begin
            n_ph[i] = 1; n_n[i] = 0; n_err[i] = 0;
         end else if (m_ph[i] == 1 && acc && last_r) n_ph[i] = 2;
         else if (m_ph[i] == 2) n_ph[i] = 0;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else begin
         m_ph = n_ph; m_n = n_n; m_err = n_err; m_we = n_we;
         m_addr = n_addr; m_data = n_data;
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(bit s, bit v, int op, logic [4:0] a, logic [4:0] b, logic [4:0] c,
                        logic [5:0] f, logic [15:0] im, logic [25:0] tg, bit l);
      start_r = s; valid_r = v; op_r = 3'(op); rs_r = a; rt_r = b; rd_r = c;
      funct_r = f; imm_r = im; tgt_r = tg; last_r = l;
      @(posedge clk); #1;
   endtask

   task automatic idle(int n);
      for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic pulse_start();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic addi(logic [15:0] im, bit l);
      drive(0, 1, 4, 5'd1, 5'd2, 0, 0, im, 0, l);
   endtask

   task automatic do_reset(int hold);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_we", 32'(we_w), 32'h0);
      chk("rst_busy", 32'(busy_w), 32'h0);
      chk("rst_done", 32'(done_w), 32'h0);
      chk("rst_err", 32'(err_w), 32'h0);
      chk("rst_ready", 32'(rdy_w), 32'h0);
      chk("rst_addr0", addr_w[0], 32'h0);
      chk("rst_addr1", addr_w[1], BASE1);
      chk("rst_wdata0", data_w[0], 32'h0);
      chk("rst_wdata1", data_w[1], 32'h0);
      for (int k = 0; k < hold; k++) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      idle(3);
      chk("init_busy", 32'(busy_w), 32'h0);
      chk("init_addr1", addr_w[1], BASE1);
      rst_n = 1'b1;
      idle(2);

      // single R-type word, done alongside the write
      log0.delete();
      pulse_start();
      drive(0, 1, 0, 5'd1, 5'd2, 5'd3, 6'b100000, 0, 0, 1);
      idle(3);
      chk("r_count", log0.size(), 1);
      if (log0.size() >= 1) begin
         chk("r_addr", log0[0].a, 32'h0);
         chk("r_data", log0[0].d, 32'h0022_1820);
         chk("r_done", 32'(log0[0].dn), 32'h1);
      end

      // LW then J back-to-back
      log0.delete();
      pulse_start();
      drive(0, 1, 1, 5'd4, 5'd5, 0, 0, 16'h0010, 0, 0);
      drive(0, 1, 6, 0, 0, 0, 0, 0, 26'h0000100, 1);
      idle(3);
      chk("lwj_count", log0.size(), 2);
      if (log0.size() >= 2) begin
         chk("lw_addr", log0[0].a, 32'h0);
         chk("lw_data", log0[0].d, 32'h8C85_0010);
         chk("lw_done", 32'(log0[0].dn), 32'h0);
         chk("j_addr", log0[1].a, 32'h4);
         chk("j_data", log0[1].d, 32'h0800_0100);
         chk("j_done", 32'(log0[1].dn), 32'h1);
      end

      // DEPTH=2 instance saturates after two words
      log1.delete();
      pulse_start();
      addi(16'h0001, 0);
      addi(16'h0002, 0);
      addi(16'h0003, 0);
      idle(2);
      chk("depth_count", log1.size(), 2);
      chk("depth_ready", 32'(rdy_w[1]), 32'h0);
      foreach (log1[k]) chk("depth_nowrap", 32'(log1[k].a == BASE1 + 8), 32'h0);
      if (log1.size() >= 2) begin
         chk("depth_a0", log1[0].a, BASE1);
         chk("depth_a1", log1[1].a, BASE1 + 4);
      end

      // illegal op between two ADDIs
      log0.delete();
      pulse_start();
      addi(16'h0005, 0);
      drive(0, 1, 7, 5'd9, 5'd9, 5'd9, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 0);
      addi(16'h0006, 1);
      idle(3);
      chk("ill_err", 32'(err_w[0]), 32'h1);
      chk("ill_count", log0.size(), 2);
      if (log0.size() >= 2) begin
         chk("ill_a0", log0[0].a, 32'h0);
         chk("ill_d0", log0[0].d, 32'h2022_0005);
         chk("ill_a1", log0[1].a, 32'h4);
         chk("ill_d1", log0[1].d, 32'h2022_0006);
      end

      // restart mid-session after three writes
      log0.delete();
      pulse_start();
      drive(0, 1, 7, 0, 0, 0, 0, 0, 0, 0);
      addi(16'h0001, 0);
      addi(16'h0002, 0);
      addi(16'h0003, 0);
      chk("rs_err_before", 32'(err_w[0]), 32'h1);
      drive(1, 1, 4, 5'd1, 5'd2, 0, 0, 16'h0009, 0, 0);
      addi(16'h0004, 1);
      chk("rs_err_after", 32'(err_w[0]), 32'h0);
      idle(3);
      chk("rs_count", log0.size(), 4);
      if (log0.size() >= 4) begin
         chk("rs_a2", log0[2].a, 32'h8);
         chk("rs_a3", log0[3].a, 32'h0);
         chk("rs_d3", log0[3].d, 32'h2022_0004);
      end

      // reset during LOAD with a bundle offered
      pulse_start();
      addi(16'h0007, 0);
      valid_r = 1'b1;
      log0.delete();
      log1.delete();
      do_reset(3);
      @(posedge clk); #1;
      idle(3);
      chk("rst_nowrites0", log0.size(), 0);
      chk("rst_nowrites1", log1.size(), 0);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 399) == 0) begin
            do_reset($urandom_range(1, 3));
            @(posedge clk); #1;
         end
         drive($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7),
               5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom), 16'($urandom),
               26'($urandom), $urandom_range(0, 7) == 0);
      end
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
